assoc_tbl_writer: RTL and testbench
===================================

ASSOC_TBL_WRITER -- requirements
Module: assoc_tbl_writer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning the number of table entries (2..64).
REQ-002 The block SHALL have parameter KEY_W, default 8, meaning the key width in bits.
REQ-003 The block SHALL have parameter DATA_W, default 8, meaning the value width in bits.
REQ-004 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-005 Port list (name, direction, width, meaning):
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  request offered.
- req_ready  out  1  block accepts the request.
- req_op  in  1  0 = write (insert or update), 1 = delete.
- req_key  in  KEY_W  request key.
- req_data  in  DATA_W  write value; ignored on delete.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer takes the response.
- rsp_status  out  2  00 inserted, 01 updated, 10 deleted, 11 error.
- count  out  clog2(DEPTH+1)  number of valid entries.
- full  out  1  count == DEPTH.
- lkp_key  in  KEY_W  combinational lookup key.
- lkp_hit  out  1  lkp_key matches a valid entry.
- lkp_data  out  DATA_W  value of the matching entry; 0 on miss.

Function
REQ-006 FSM states SHALL be IDLE, SCAN, COMMIT and RESP.
REQ-007 IDLE SHALL drive req_ready=1; on req_valid&&req_ready it SHALL capture op, key and data, clear idx, found and free_seen, and go to SCAN.
REQ-008 req_ready SHALL be 0 in every state except IDLE; only one request SHALL be in flight.
REQ-009 SCAN SHALL examine entry idx once per cycle: valid && key match records hit_idx and sets found; the first invalid entry (lowest index) records free_idx and sets free_seen.
REQ-010 SCAN SHALL go to COMMIT when idx == DEPTH-1, so the scan always lasts exactly DEPTH cycles; keys are unique, so at most one entry matches.
REQ-011 COMMIT, write with found, SHALL overwrite data at hit_idx and set status 01 (updated).
REQ-012 COMMIT, write without found but with free_seen, SHALL set valid, key and data at free_idx, increment count and set status 00 (inserted).
REQ-013 COMMIT, write with neither found nor free_seen (table full), SHALL leave the table unchanged and set status 11 (error).
REQ-014 COMMIT, delete with found, SHALL clear valid at hit_idx, decrement count and set status 10 (deleted).
REQ-015 COMMIT, delete without found, SHALL leave the table unchanged and set status 11 (error).
REQ-016 COMMIT SHALL always go to RESP after one cycle.
REQ-017 RESP SHALL hold rsp_valid=1 with rsp_status stable until rsp_ready, then go to IDLE; rsp_ready while rsp_valid=0 SHALL be ignored.
REQ-018 Latency SHALL be DEPTH+2 cycles from the accepting edge to the first cycle rsp_valid=1.
REQ-019 The lookup port SHALL be combinational over committed state; a COMMIT update SHALL be visible on lkp_* from the cycle after the COMMIT edge.
REQ-020 A lookup in the same cycle as COMMIT SHALL return the pre-commit value.
REQ-021 count SHALL never exceed DEPTH or underflow; full SHALL be derived from count.

Reset
REQ-022 While rst=1 at a clock edge, the block SHALL clear all valid bits, set count=0, state=IDLE, rsp_valid=0 and rsp_status=00.
REQ-023 req_ready SHALL be 0 during any cycle rst=1.
REQ-024 Reset asserted mid-operation SHALL abandon the in-flight request and produce no response.
REQ-025 Key and data storage need not be reset.

Structure
REQ-026 Package assoc_tbl_pkg SHALL hold the op type, the status type (four codes), the state type, and the status constants.
REQ-027 Sub-module assoc_tbl_store SHALL hold the valid, key and data arrays with one write port and the combinational lookup; the FSM and counters SHALL stay in assoc_tbl_writer.

Verification (DEPTH=4)
REQ-028 Reset, then write key 0x11 data 0xA5 -> rsp 00 at cycle +6; count=1; lkp_key 0x11 gives hit=1, data=0xA5.
REQ-029 Write 0x11 data 0x3C after REQ-028 -> rsp 01; count stays 1; lkp_data=0x3C.
REQ-030 Fill keys 0x01..0x04, then write 0x05 -> rsp 11; full=1; count=4; 0x05 misses.
REQ-031 Delete 0x02 from the full table -> rsp 10; count=3; write 0x05 -> rsp 00 into index 1; 0x05 hits.
REQ-032 Delete absent key 0x77 -> rsp 11; table unchanged; hold rsp_ready=0 for 5 cycles -> rsp_valid and status stable, req_ready=0.
REQ-033 Assert rst during SCAN -> no response; next cycle count=0, req_ready=1, all lookups miss.

Source files
------------

// File: rtl/assoc_tbl_pkg.sv
// Shared types and constants for the associative table writer.
package assoc_tbl_pkg;

  // Request operation encoding.
  typedef enum logic {
    OP_WRITE  = 1'b0,
    OP_DELETE = 1'b1
  } op_e;

  // Response status codes.
  localparam logic [1:0] STATUS_INSERTED = 2'b00;
  localparam logic [1:0] STATUS_UPDATED  = 2'b01;
  localparam logic [1:0] STATUS_DELETED  = 2'b10;
  localparam logic [1:0] STATUS_ERROR    = 2'b11;

  typedef enum logic [1:0] {
    RSP_INSERTED = STATUS_INSERTED,
    RSP_UPDATED  = STATUS_UPDATED,
    RSP_DELETED  = STATUS_DELETED,
    RSP_ERROR    = STATUS_ERROR
  } status_e;

  // Writer FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SCAN   = 2'b01,
    COMMIT = 2'b10,
    RESP   = 2'b11
  } state_e;

endpackage

// File: rtl/assoc_tbl_store.sv
// Table storage: valid/key/data arrays, one write port, one scan read port
// and a fully combinational key lookup over the committed contents.
module assoc_tbl_store #(
  parameter int DEPTH  = 8,
  parameter int KEY_W  = 8,
  parameter int DATA_W = 8,
  parameter int IDX_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic              wr_valid,
  input  logic              wr_kd_en,
  input  logic [KEY_W-1:0]  wr_key,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [KEY_W-1:0]  rd_key,
  input  logic [KEY_W-1:0]  lkp_key,
  output logic              lkp_hit,
  output logic [DATA_W-1:0] lkp_data
);

  logic [DEPTH-1:0]  valid_r;
  logic [KEY_W-1:0]  key_r  [DEPTH];
  logic [DATA_W-1:0] data_r [DEPTH];
  logic [DEPTH-1:0]  match_s;

  // Valid bits: cleared by reset, otherwise written through the single write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= '0;
    end else if (wr_en) begin
      valid_r[wr_idx] <= wr_valid;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Key/data payload: no reset needed, contents only matter behind a valid bit.
  always_ff @(posedge clk) begin
    if (wr_en && wr_kd_en) begin
      key_r[wr_idx]  <= wr_key;
      data_r[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_r[rd_idx];
  assign rd_key   = key_r[rd_idx];

  // Lookup: keys are unique, so OR-ing the masked data of all matches is exact.
  always_comb begin
    match_s  = '0;
    lkp_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_s[i] = valid_r[i] && (key_r[i] == lkp_key);
      lkp_data   = lkp_data | ({DATA_W{match_s[i]}} & data_r[i]);
    end
    lkp_hit = |match_s;
  end

endmodule

// File: rtl/assoc_tbl_writer.sv
// Associative table writer: one request at a time is scanned against every
// entry, committed in a single cycle, then reported through a held response.
module assoc_tbl_writer
  import assoc_tbl_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int KEY_W  = 8,
  parameter int DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_op,
  input  logic [KEY_W-1:0]           req_key,
  input  logic [DATA_W-1:0]          req_data,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [1:0]                 rsp_status,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  input  logic [KEY_W-1:0]           lkp_key,
  output logic                       lkp_hit,
  output logic [DATA_W-1:0]          lkp_data
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  state_e            state_r;
  op_e               op_r;
  logic [KEY_W-1:0]  key_r;
  logic [DATA_W-1:0] data_r;
  logic [IDX_W-1:0]  idx_r;
  logic              found_r;
  logic              free_seen_r;
  logic [IDX_W-1:0]  hit_idx_r;
  logic [IDX_W-1:0]  free_idx_r;
  logic [CNT_W-1:0]  count_r;
  logic              rsp_valid_r;
  status_e           rsp_status_r;

  logic              wr_en_s;
  logic [IDX_W-1:0]  wr_idx_s;
  logic              wr_valid_s;
  logic              wr_kd_en_s;
  logic              rd_valid_s;
  logic [KEY_W-1:0]  rd_key_s;
  status_e           commit_status_s;
  logic [CNT_W-1:0]  count_next_s;

  assoc_tbl_store #(
    .DEPTH  (DEPTH),
    .KEY_W  (KEY_W),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_store (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en_s),
    .wr_idx   (wr_idx_s),
    .wr_valid (wr_valid_s),
    .wr_kd_en (wr_kd_en_s),
    .wr_key   (key_r),
    .wr_data  (data_r),
    .rd_idx   (idx_r),
    .rd_valid (rd_valid_s),
    .rd_key   (rd_key_s),
    .lkp_key  (lkp_key),
    .lkp_hit  (lkp_hit),
    .lkp_data (lkp_data)
  );

  // Commit decision: table write, resulting status and next count, all from scan results.
  always_comb begin
    wr_en_s         = 1'b0;
    wr_idx_s        = hit_idx_r;
    wr_valid_s      = 1'b0;
    wr_kd_en_s      = 1'b0;
    commit_status_s = RSP_ERROR;
    count_next_s    = count_r;
    case (state_r)
      COMMIT: begin
        if (op_r == OP_WRITE) begin
          if (found_r) begin
            wr_en_s         = 1'b1;
            wr_idx_s        = hit_idx_r;
            wr_valid_s      = 1'b1;
            wr_kd_en_s      = 1'b1;
            commit_status_s = RSP_UPDATED;
          end else if (free_seen_r && (count_r != DEPTH_CNT)) begin
            wr_en_s         = 1'b1;
            wr_idx_s        = free_idx_r;
            wr_valid_s      = 1'b1;
            wr_kd_en_s      = 1'b1;
            commit_status_s = RSP_INSERTED;
            count_next_s    = count_r + CNT_W'(1);
          end else begin
            commit_status_s = RSP_ERROR;
          end
        end else begin
          if (found_r && (count_r != '0)) begin
            wr_en_s         = 1'b1;
            wr_idx_s        = hit_idx_r;
            wr_valid_s      = 1'b0;
            commit_status_s = RSP_DELETED;
            count_next_s    = count_r - CNT_W'(1);
          end else begin
            commit_status_s = RSP_ERROR;
          end
        end
      end
      default: begin
        wr_en_s = 1'b0;
      end
    endcase
  end

  // Request FSM: capture, linear scan over all entries, single-cycle commit, held response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      count_r      <= '0;
      rsp_valid_r  <= 1'b0;
      rsp_status_r <= RSP_INSERTED;
      idx_r        <= '0;
      found_r      <= 1'b0;
      free_seen_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid && req_ready) begin
            op_r        <= op_e'(req_op);
            key_r       <= req_key;
            data_r      <= req_data;
            idx_r       <= '0;
            found_r     <= 1'b0;
            free_seen_r <= 1'b0;
            state_r     <= SCAN;
          end
        end
        SCAN: begin
          if (rd_valid_s && (rd_key_s == key_r)) begin
            found_r   <= 1'b1;
            hit_idx_r <= idx_r;
          end
          if (!rd_valid_s && !free_seen_r) begin
            free_seen_r <= 1'b1;
            free_idx_r  <= idx_r;
          end
          if (idx_r == LAST_IDX) begin
            state_r <= COMMIT;
          end else begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        COMMIT: begin
          count_r      <= count_next_s;
          rsp_status_r <= commit_status_s;
          rsp_valid_r  <= 1'b1;
          state_r      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign req_ready  = (state_r == IDLE) && !rst;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_status = rsp_status_r;
  assign count      = count_r;
  assign full       = (count_r == DEPTH_CNT);

endmodule

// File: tb/tb_assoc_tbl_writer.sv
// Self-checking bench for assoc_tbl_writer (DEPTH=4) with a table-level model.
module tb_assoc_tbl_writer;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_op = 1'b0;
  logic [7:0] req_key = 8'h00;
  logic [7:0] req_data = 8'h00;
  logic       rsp_ready = 1'b0;
  logic [7:0] lkp_key = 8'h00;
  logic       req_ready;
  logic       rsp_valid;
  logic [1:0] rsp_status;
  logic [2:0] count;
  logic       full;
  logic       lkp_hit;
  logic [7:0] lkp_data;

  always #5 clk = ~clk;

  assoc_tbl_writer #(.DEPTH(DEPTH), .KEY_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_key(req_key), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
    .count(count), .full(full),
    .lkp_key(lkp_key), .lkp_hit(lkp_hit), .lkp_data(lkp_data)
  );

  int errors = 0;
  int checks = 0;

  // Model: the table as a set of (key,data) slots, plus transaction phase flags.
  bit         m_valid [DEPTH];
  logic [7:0] m_key   [DEPTH];
  logic [7:0] m_data  [DEPTH];
  bit         model_ok = 1'b0;
  bit         busy = 1'b0;
  bit         exp_rv = 1'b0;
  logic [1:0] exp_status = 2'b00;
  bit         lkp_auto = 1'b1;
  logic [7:0] lkp_keys [8] = '{8'h11, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h77, 8'h22};
  bit         cmp_h;
  logic [7:0] cmp_d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) c += m_valid[i] ? 1 : 0;
    return c;
  endfunction

  task automatic m_lookup(input logic [7:0] k, output bit h, output logic [7:0] d);
    h = 1'b0;
    d = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      if (m_valid[i] && m_key[i] == k) begin
        h = 1'b1;
        d = m_data[i];
      end
    end
  endtask

  task automatic m_clear();
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
  endtask

  task automatic model_apply(input bit op, input logic [7:0] k, input logic [7:0] d,
                             output logic [1:0] st);
    int hit = -1;
    int fr = -1;
    for (int i = 0; i < DEPTH; i++) if (m_valid[i] && m_key[i] == k) hit = i;
    for (int i = DEPTH - 1; i >= 0; i--) if (!m_valid[i]) fr = i;
    if (!op) begin
      if (hit >= 0) begin
        m_data[hit] = d;
        st = 2'b01;
      end else if (fr >= 0) begin
        m_valid[fr] = 1'b1;
        m_key[fr] = k;
        m_data[fr] = d;
        st = 2'b00;
      end else begin
        st = 2'b11;
      end
    end else if (hit >= 0) begin
      m_valid[hit] = 1'b0;
      st = 2'b10;
    end else begin
      st = 2'b11;
    end
  endtask

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (model_ok) begin
      if (rst) begin
        chk("req_ready_in_reset", 32'(req_ready), 32'd0);
      end else begin
        chk("req_ready", 32'(req_ready), 32'(!busy));
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        if (exp_rv) chk("rsp_status", 32'(rsp_status), 32'(exp_status));
        chk("count", 32'(count), 32'(m_count()));
        chk("full", 32'(full), 32'(m_count() == DEPTH));
        m_lookup(lkp_key, cmp_h, cmp_d);
        chk("lkp_hit", 32'(lkp_hit), 32'(cmp_h));
        chk("lkp_data", 32'(lkp_data), 32'(cmp_d));
      end
    end
  end

  // Background lookup key rotation when no directed key is being held.
  initial begin
    int k = 0;
    forever begin
      @(posedge clk);
      #2;
      if (lkp_auto) begin
        lkp_key = lkp_keys[k];
        k = (k + 1) % 8;
      end
    end
  end

  task automatic set_lkp(input logic [7:0] k);
    lkp_auto = 1'b0;
    @(posedge clk);
    #2 lkp_key = k;
    @(negedge clk);
  endtask

  // One request: returns the status seen just before the response handshake and
  // the cycle (accepting edge counted as 1) in which rsp_valid first appeared.
  task automatic do_req(input bit op, input logic [7:0] k, input logic [7:0] d, input int hold,
                        output logic [1:0] got, output int lat);
    int n = 0;
    logic [1:0] st;
    got = 2'bxx;
    lat = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_op = op;
    req_key = k;
    req_data = d;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    busy = 1'b1;
    #1 req_valid = 1'b0;
    for (int i = 2; i <= DEPTH + 2; i++) begin
      @(posedge clk);
      if (i == DEPTH + 2) begin
        model_apply(op, k, d, st);
        exp_status = st;
        exp_rv = 1'b1;
      end
      @(negedge clk);
      if (rsp_valid && lat == 0) lat = i;
    end
    repeat (hold) @(negedge clk);
    got = rsp_status;
    rsp_ready = 1'b1;
    @(posedge clk);
    busy = 1'b0;
    exp_rv = 1'b0;
    #1 rsp_ready = 1'b0;
  endtask

  logic [1:0] got;
  int lat;

  initial begin
    int n;
    m_clear();
    repeat (2) @(posedge clk);
    model_ok = 1'b1;
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd1);

    // Insert, then update the same key while looking it up across the commit.
    set_lkp(8'h11);
    do_req(1'b0, 8'h11, 8'hA5, 0, got, lat);
    chk("w1_status", 32'(got), 32'h0);
    chk("w1_latency", 32'(lat), 32'd6);
    @(negedge clk);
    chk("w1_count", 32'(count), 32'd1);
    chk("w1_hit", 32'(lkp_hit), 32'd1);
    chk("w1_data", 32'(lkp_data), 32'hA5);
    do_req(1'b0, 8'h11, 8'h3C, 0, got, lat);
    chk("upd_status", 32'(got), 32'h1);
    @(negedge clk);
    chk("upd_count", 32'(count), 32'd1);
    chk("upd_data", 32'(lkp_data), 32'h3C);
    do_req(1'b1, 8'h11, 8'h00, 0, got, lat);
    chk("del11_status", 32'(got), 32'h2);

    // Fill the table, then overflow it.
    lkp_auto = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      do_req(1'b0, 8'(k), 8'(8'hD0 + k), 0, got, lat);
      chk("fill_status", 32'(got), 32'h0);
    end
    do_req(1'b0, 8'h05, 8'h55, 0, got, lat);
    chk("ovf_status", 32'(got), 32'h3);
    set_lkp(8'h05);
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_count", 32'(count), 32'd4);
    chk("ovf_miss", 32'(lkp_hit), 32'd0);

    // Free a slot and reuse it.
    do_req(1'b1, 8'h02, 8'h00, 0, got, lat);
    chk("del02_status", 32'(got), 32'h2);
    @(negedge clk);
    chk("del02_count", 32'(count), 32'd3);
    do_req(1'b0, 8'h05, 8'h5A, 0, got, lat);
    chk("ins05_status", 32'(got), 32'h0);
    set_lkp(8'h05);
    chk("ins05_hit", 32'(lkp_hit), 32'd1);
    chk("ins05_data", 32'(lkp_data), 32'h5A);
    set_lkp(8'h02);
    chk("del02_miss", 32'(lkp_hit), 32'd0);

    // Delete of an absent key with a stalled consumer.
    lkp_auto = 1'b1;
    do_req(1'b1, 8'h77, 8'h00, 5, got, lat);
    chk("del77_status", 32'(got), 32'h3);
    @(negedge clk);
    chk("del77_count", 32'(count), 32'd4);

    // rsp_ready with no response pending must do nothing.
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    rsp_ready = 1'b0;

    // Reset in the middle of a scan.
    @(negedge clk);
    req_valid = 1'b1;
    req_op = 1'b0;
    req_key = 8'h33;
    req_data = 8'h44;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    busy = 1'b1;
    #1 req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    m_clear();
    busy = 1'b0;
    exp_rv = 1'b0;
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_count", 32'(count), 32'd0);
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    for (int k = 1; k <= 5; k++) begin
      set_lkp(8'(k));
      chk("abort_miss", 32'(lkp_hit), 32'd0);
    end
    lkp_auto = 1'b1;
    repeat (8) @(negedge clk);
    do_req(1'b0, 8'h22, 8'h99, 0, got, lat);
    chk("post_reset_status", 32'(got), 32'h0);
    @(negedge clk);
    chk("post_reset_count", 32'(count), 32'd1);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
